huff_lut_ram: RTL

HUFF_LUT_RAM -- requirements
Module: huff_lut_ram

---
 rtl/huff_pkg.sv | 21 ++
 rtl/huff_lut_mem.sv | 39 +++
 rtl/huff_lut_ram.sv | 122 ++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman size/run lookup table: default geometry
// and the controller state encoding.
package huff_pkg;

   localparam int unsigned HUFF_DEPTH  = 53;
   localparam int unsigned HUFF_ADDR_W = 6;
   localparam int unsigned HUFF_SIZE_W = 4;
   localparam int unsigned HUFF_RUN_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } huff_state_e;

   // True when an address falls inside a table of the given depth.
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/huff_lut_mem.sv
// One-write, one-read synchronous RAM; the read register holds its value
// between enabled reads, so it doubles as the latched lookup result.
module huff_lut_mem #(
   parameter int unsigned DEPTH  = 53,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 6
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Table contents are never reset; they are rebuilt by a full load.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read sees the pre-write contents when both ports hit the same entry.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/huff_lut_ram.sv
// Huffman coefficient-size / run-length lookup table with a streaming bulk
// loader, single-entry runtime updates and 1-cycle registered lookups.
module huff_lut_ram
   import huff_pkg::*;
#(
   parameter int unsigned DEPTH  = HUFF_DEPTH,
   parameter int unsigned ADDR_W = HUFF_ADDR_W,
   parameter int unsigned SIZE_W = HUFF_SIZE_W,
   parameter int unsigned RUN_W  = HUFF_RUN_W
) (
   input  logic              phi1,
   input  logic              reset,
   input  logic              init_start,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [SIZE_W-1:0] wr_size,
   input  logic [RUN_W-1:0]  wr_run,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic              rd_err,
   output logic [SIZE_W-1:0] coeff_size,
   output logic [RUN_W-1:0]  run_length,
   output logic              init_done
);

   localparam int unsigned       DATA_W    = SIZE_W + RUN_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   huff_state_e       r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_wr_ready;
   logic              r_init_done;
   logic              r_rd_valid;
   logic              r_rd_err;

   logic              w_rd_ok;
   logic              w_load_we;
   logic              w_upd_we;
   logic              w_we;
   logic              w_re;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;

   // A lookup colliding with a reload start is rejected, even from READY.
   assign w_rd_ok   = rd_req && (r_state == ST_READY) && !init_start
                      && addr_in_range(32'(rd_addr), DEPTH);
   assign w_load_we = (r_state == ST_LOAD) && wr_valid && !init_start;
   assign w_upd_we  = upd_en && (r_state == ST_READY)
                      && addr_in_range(32'(upd_addr), DEPTH);
   assign w_we      = !reset && (w_load_we || w_upd_we);
   assign w_re      = !reset && w_rd_ok;
   assign w_waddr   = w_load_we ? r_wr_ptr : upd_addr;
   assign w_wdata   = {wr_size, wr_run};

   always_ff @(posedge phi1) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_wr_ready  <= 1'b0;
         r_init_done <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_rd_valid <= rd_req;
         r_rd_err   <= rd_req && !w_rd_ok;
         if (init_start) begin
            r_state     <= ST_LOAD;
            r_wr_ptr    <= '0;
            r_wr_ready  <= 1'b1;
            r_init_done <= 1'b0;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  // Pointer stops at the last entry; the load then closes.
                  if (wr_valid) begin
                     if (r_wr_ptr == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_wr_ready  <= 1'b0;
                        r_init_done <= 1'b1;
                     end else begin
                        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                     end
                  end
               end
               ST_READY: begin
                  r_state <= ST_READY;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   huff_lut_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .i_clk   (phi1),
      .i_reset (reset),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (rd_addr),
      .o_rdata (w_rdata)
   );

   assign wr_ready   = r_wr_ready;
   assign init_done  = r_init_done;
   assign rd_valid   = r_rd_valid;
   assign rd_err     = r_rd_err;
   assign coeff_size = w_rdata[DATA_W-1:RUN_W];
   assign run_length = w_rdata[RUN_W-1:0];

endmodule
